// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin owner of a shared 4x1 mux select.
// Ports: clk, reset (sync, active-high), req[3:0] -> grant[3:0], sel0, sel1, busy.
// Optional macro ARB_BURST_LIMIT_EN enables forced handover after MAX_BURST cycles.
module mux_sel_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       sel0,
  output logic       sel1,
  output logic       busy
);

  if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("MAX_BURST out of range 2..255");
  end

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;

  logic [3:0] elig;
  logic       arb;
  logic       found;
  logic [1:0] win;
  logic [1:0] idx;

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [7:0] BURST = 8'(MAX_BURST);
  logic [7:0] cnt_q, cnt_d;
  logic       others;
`endif

  // Owner index is always the registered select value.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    elig    = req;
    arb     = 1'b0;
    found   = 1'b0;
    win     = ptr_q;
    idx     = '0;
`ifdef ARB_BURST_LIMIT_EN
    cnt_d   = cnt_q;
    others  = |(req & ~grant_q);
`endif

    unique case (state_q)
      IDLE: arb = 1'b1;
      OWNED: begin
        if (!req[sel_q]) begin
          arb = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
        end else if (cnt_q == BURST && others) begin
          // Preempted owner still requests; keep it out of this round.
          arb  = 1'b1;
          elig = req & ~grant_q;
`endif
        end
      end
      default: arb = 1'b1;
    endcase

    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    if (arb) begin
      if (found) begin
        state_d = OWNED;
        grant_d = 4'b0001 << win;
        sel_d   = win;
        ptr_d   = win + 2'd1;
        busy_d  = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
        // The grant cycle itself counts as the first owned cycle.
        cnt_d   = 8'd1;
`endif
      end else begin
        // Select is left alone so the mux output stays quiet.
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
        cnt_d   = '0;
`endif
      end
`ifdef ARB_BURST_LIMIT_EN
    end else if (state_q == OWNED && cnt_q != BURST) begin
      cnt_d = cnt_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant = grant_q;
  assign sel0  = sel_q[0];
  assign sel1  = sel_q[1];
  assign busy  = busy_q;

endmodule
